// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the non-pipelined MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and decodes the datapath
// control strobes combinationally from the current state and mem_ready.
module multicycle_control #(
    parameter int unsigned CNT_W           = 16,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0]       OP_RTYPE = 6'b000000;
    localparam logic [5:0]       OP_LW    = 6'b100011;
    localparam logic [5:0]       OP_SW    = 6'b101011;
    localparam logic [5:0]       OP_BEQ   = 6'b000100;
    localparam logic [5:0]       OP_J     = 6'b000010;
    localparam logic [5:0]       OP_ADDI  = 6'b001000;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    state_t     state_q;
    logic [5:0] opcode;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign state  = state_q;

    // State sequencing, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state_q <= S_EXEC;
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        default: begin
                            illegal_op <= 1'b1;
                            if (HALT_ON_ILLEGAL) begin
                                state_q <= S_HALT;
                            end else begin
                                state_q     <= S_FETCH;
                                instr_count <= instr_count + CNT_ONE;
                            end
                        end
                    endcase
                end
                S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR: begin
                    if (mem_ready) begin
                        state_q     <= S_FETCH;
                        instr_count <= instr_count + CNT_ONE;
                    end
                end
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                    state_q     <= S_FETCH;
                    instr_count <= instr_count + CNT_ONE;
                end
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Control decode; everything held low while in reset so no write escapes
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'd3;
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = (rt != 5'd0);
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = (rd != 5'd0);
                end
                S_ADDIWB: reg_write = (rt != 5'd0);
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'd1;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    // Control vector layout:
    // [15]pc_write [14]pc_write_cond [13]i_or_d [12]mem_read [11]mem_write
    // [10]ir_write [9]reg_dst [8]mem_to_reg [7]reg_write [6]alu_src_a
    // [5:4]alu_src_b [3:2]alu_op [1:0]pc_source
    localparam logic [15:0] C_NONE   = 16'h0000;
    localparam logic [15:0] C_FETCH  = 16'h9410;
    localparam logic [15:0] C_FWAIT  = 16'h1010;
    localparam logic [15:0] C_DECODE = 16'h0030;
    localparam logic [15:0] C_EXEC   = 16'h0048;
    localparam logic [15:0] C_ALUWB  = 16'h0280;
    localparam logic [15:0] C_MEMADR = 16'h0060;
    localparam logic [15:0] C_MEMRD  = 16'h3000;
    localparam logic [15:0] C_MEMWB  = 16'h0180;
    localparam logic [15:0] C_MEMWR  = 16'h2800;
    localparam logic [15:0] C_BRANCH = 16'h4045;
    localparam logic [15:0] C_JUMP   = 16'h8002;
    localparam logic [15:0] C_ADDIEX = 16'h0060;

    logic        clk = 1'b0;
    logic        rst_n, rst_b_n, zero, mem_ready;
    logic [31:0] instr, instr_b;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal_op;
    logic [3:0] instr_count;
    logic [15:0] ctl_a;

    logic       pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b;
    logic       reg_dst_b, mem_to_reg_b, reg_write_b, alu_src_a_b;
    logic [1:0] alu_src_b_b, alu_op_b, pc_source_b;
    logic [3:0] state_b;
    logic       illegal_op_b;
    logic [7:0] instr_count_b;
    logic [15:0] ctl_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign ctl_a = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    assign ctl_b = {pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b,
                    reg_dst_b, mem_to_reg_b, reg_write_b, alu_src_a_b, alu_src_b_b, alu_op_b,
                    pc_source_b};

    multicycle_control #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(8), .HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .instr(instr_b), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .i_or_d(i_or_d_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
        .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .pc_source(pc_source_b), .state(state_b), .illegal_op(illegal_op_b),
        .instr_count(instr_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        rst_b_n   = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        instr     = 32'h0;
        instr_b   = 32'hFC000000;
        #1;
        chk("rst_ctl_pre", ctl_a, C_NONE);
        tick();
        chk("rst_state", state, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_ctl_held", ctl_a, C_NONE);

        // add $3,$1,$2
        rst_n   = 1'b1;
        rst_b_n = 1'b1;
        instr   = 32'h00221820;
        #1;
        chk("add_fetch_ctl", ctl_a, C_FETCH);
        chk("b_fetch_ctl", ctl_b, C_FETCH);
        tick();
        chk("add_dec_state", state, 1);
        chk("add_dec_ctl", ctl_a, C_DECODE);
        chk("b_dec_state", state_b, 1);
        chk("b_dec_ctl", ctl_b, C_DECODE);
        tick();
        chk("add_exec_state", state, 6);
        chk("add_exec_ctl", ctl_a, C_EXEC);
        chk("b_nohalt_state", state_b, 0);
        chk("b_illegal", illegal_op_b, 1);
        chk("b_count", instr_count_b, 1);
        rst_b_n = 1'b0;
        tick();
        chk("add_wb_state", state, 7);
        chk("add_wb_ctl", ctl_a, C_ALUWB);
        chk("add_wb_count", instr_count, 0);
        tick();
        chk("add_ret_state", state, 0);
        chk("add_ret_count", instr_count, 1);

        // lw $5,8($0) with two wait cycles in MEMRD
        instr = 32'h8C050008;
        tick();
        chk("lw_dec_state", state, 1);
        tick();
        chk("lw_adr_state", state, 2);
        chk("lw_adr_ctl", ctl_a, C_MEMADR);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("lw_rd0_state", state, 3);
        chk("lw_rd0_ctl", ctl_a, C_MEMRD);
        tick();
        chk("lw_rd1_state", state, 3);
        chk("lw_rd1_ctl", ctl_a, C_MEMRD);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("lw_rd2_state", state, 3);
        chk("lw_rd2_ctl", ctl_a, C_MEMRD);
        tick();
        chk("lw_wb_state", state, 4);
        chk("lw_wb_ctl", ctl_a, C_MEMWB);
        tick();
        chk("lw_ret_state", state, 0);
        chk("lw_ret_count", instr_count, 2);

        // addi $0,$0,5: writeback suppressed
        instr = 32'h20000005;
        tick();
        tick();
        chk("addi_ex_state", state, 10);
        chk("addi_ex_ctl", ctl_a, C_ADDIEX);
        tick();
        chk("addi_wb_state", state, 11);
        chk("addi_wb_ctl", ctl_a, C_NONE);
        tick();
        chk("addi_ret_state", state, 0);
        chk("addi_ret_count", instr_count, 3);

        // beq taken then not taken
        instr = 32'h10220003;
        zero  = 1'b1;
        tick();
        tick();
        chk("beq1_state", state, 8);
        chk("beq1_ctl", ctl_a, C_BRANCH);
        tick();
        chk("beq1_count", instr_count, 4);
        zero = 1'b0;
        tick();
        tick();
        chk("beq0_state", state, 8);
        chk("beq0_ctl", ctl_a, C_BRANCH);
        tick();
        chk("beq0_ret_state", state, 0);
        chk("beq0_count", instr_count, 5);

        // illegal opcode halts
        instr = 32'hFC000000;
        tick();
        chk("ill_dec_state", state, 1);
        tick();
        chk("ill_illegal", illegal_op, 1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_state", state, 12);
            chk("halt_ctl", ctl_a, C_NONE);
            tick();
        end
        chk("halt_count", instr_count, 5);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_ctl", ctl_a, C_NONE);
        tick();
        chk("halt_rst_state", state, 0);
        chk("halt_rst_illegal", illegal_op, 0);
        chk("halt_rst_count", instr_count, 0);
        rst_n = 1'b1;

        // 16 jumps wrap the 4-bit counter, then one more
        instr = 32'h08000000;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] exp_cnt;
            exp_cnt = 4'((i + 1) % 16);
            tick();
            tick();
            chk("j_state", state, 9);
            chk("j_ctl", ctl_a, C_JUMP);
            tick();
            chk("j_count", instr_count, exp_cnt);
        end

        // sw with fetch wait and one MEMWR wait
        instr     = 32'hAC050008;
        mem_ready = 1'b0;
        #1;
        chk("sw_fwait_ctl", ctl_a, C_FWAIT);
        tick();
        chk("sw_fwait_state", state, 0);
        mem_ready = 1'b1;
        tick();
        tick();
        chk("sw_adr_state", state, 2);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_wr_state", state, 5);
        chk("sw_wr_ctl", ctl_a, C_MEMWR);
        tick();
        chk("sw_wr_hold", state, 5);
        mem_ready = 1'b1;
        tick();
        chk("sw_ret_state", state, 0);
        chk("sw_ret_count", instr_count, 2);

        // reset while in MEMWR with mem_ready high
        tick();
        tick();
        tick();
        chk("sw2_wr_state", state, 5);
        rst_n = 1'b0;
        #1;
        chk("sw2_rst_ctl", ctl_a, C_NONE);
        tick();
        chk("sw2_rst_state", state, 0);
        chk("sw2_rst_count", instr_count, 0);
        rst_n = 1'b1;
        #1;
        chk("sw2_post_ctl", ctl_a, C_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
